shift_right_sequential: RTL



---
 rtl/shift_right_sequential_if.sv | 27 ++
 rtl/shift_right_sequential.sv | 91 +++++++++
 2 files changed

// File: rtl/shift_right_sequential_if.sv
// Operand and result handshake bundle for the sequential right shifter.
// master drives operands and accepts results; slave is the shifter itself.
interface shift_right_sequential_if #(
    parameter int N = 32
);
    localparam int L = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in;
    logic [L-1:0] shamt;
    logic         arith;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         busy;

    modport master (
        output in_valid, in, shamt, arith, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, in, shamt, arith, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/shift_right_sequential.sv
// Multi-cycle logical/arithmetic right shifter: one power-of-two barrel step per clock,
// always L steps per operation so latency is independent of the shift amount.
module shift_right_sequential #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_right_sequential_if.slave bus
);
    localparam int L = $clog2(N);
    localparam logic [L-1:0] LAST_STAGE = L[L-1:0] - 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t       state_reg;
    logic [N-1:0] work_reg;
    logic [N-1:0] out_reg;
    logic [L-1:0] shamt_reg;
    logic [L-1:0] stage_reg;
    logic         arith_reg;
    logic         sign_reg;
    logic         out_valid_reg;

    logic         fill;
    logic [N-1:0] stage_shift [L];
    logic [N-1:0] work_next;

    // Fill comes from the operand's original sign bit, not the partially shifted word.
    assign fill = arith_reg & sign_reg;

    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_stage
            assign stage_shift[gi] = {{(2**gi){fill}}, work_reg[N-1:2**gi]};
        end
    endgenerate

    assign work_next = shamt_reg[stage_reg] ? stage_shift[stage_reg] : work_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            work_reg      <= '0;
            out_reg       <= '0;
            shamt_reg     <= '0;
            stage_reg     <= '0;
            arith_reg     <= 1'b0;
            sign_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_reg  <= bus.in;
                        shamt_reg <= bus.shamt;
                        arith_reg <= bus.arith;
                        sign_reg  <= bus.in[N-1];
                        stage_reg <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_reg <= work_next;
                    if (stage_reg == LAST_STAGE) begin
                        out_reg       <= work_next;
                        out_valid_reg <= 1'b1;
                        stage_reg     <= '0;
                        state_reg     <= DONE;
                    end else begin
                        stage_reg <= stage_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.out       = out_reg;
endmodule
